// File: rtl/lc3_display_tx.sv
// lc3_display_tx: buffers characters written to the LC3 DDR and sends
// them as 8N1 UART on tx; ready feeds DSR[15] of the screen register.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   wr_ddr     one-cycle write strobe; ddr[7:0] is queued
//   ddr        DDR contents (ddr[15:8] unused)
//   ready      FIFO not full
//   busy       a frame is on the line or characters are pending
//   overflow   sticky; a write was dropped on a full FIFO
//   fifo_count number of buffered characters
//   tx         serial output, idle high
//
// Optional: define LC3_DISPLAY_PARITY_EN to append an even parity bit
// between the data bits and the stop bit (8E1 framing).

module lc3_display_tx #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_ddr,
    input  logic [15:0]        ddr,
    output logic               ready,
    output logic               busy,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [FIFO_AW:0] FULL     = DEPTH[FIFO_AW:0];
    localparam logic [BW-1:0]    BAUD_MAX = BW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef LC3_DISPLAY_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [FIFO_AW:0]   count_nxt;
    logic [BW-1:0]      baud;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic               tx_bit;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               unused_ddr_hi;
`ifdef LC3_DISPLAY_PARITY_EN
    logic               par_bit;
`endif

    assign unused_ddr_hi = ^ddr[15:8];

    assign full  = (fifo_count == FULL);
    assign empty = (fifo_count == '0);
    // A write at full is dropped even if the head pops this cycle.
    assign push  = wr_ddr && !full;
    assign pop   = (state == IDLE) && !empty;

    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop) begin
            count_nxt = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = fifo_count - 1'b1;
        end
    end

    // Line level for the current state; registered into tx below.
    always_comb begin
        tx_bit = 1'b1;
        unique case (state)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = shreg[0];
`ifdef LC3_DISPLAY_PARITY_EN
            PARITY:  tx_bit = par_bit;
`endif
            default: tx_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= ddr[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            tx         <= 1'b1;
            baud       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
`ifdef LC3_DISPLAY_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (wr_ddr && full) begin
                overflow <= 1'b1;
            end
            fifo_count <= count_nxt;
            ready      <= (count_nxt != FULL);
            busy       <= (state != IDLE) || !empty;
            tx         <= tx_bit;

            if (state == IDLE) begin
                if (!empty) begin
                    shreg   <= mem[rptr];
`ifdef LC3_DISPLAY_PARITY_EN
                    par_bit <= ^mem[rptr];
`endif
                    baud    <= BAUD_MAX;
                    bit_idx <= '0;
                    state   <= START;
                end
            end else if (baud != '0) begin
                baud <= baud - 1'b1;
            end else begin
                baud <= BAUD_MAX;
                unique case (state)
                    START: state <= DATA;
                    DATA: begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef LC3_DISPLAY_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef LC3_DISPLAY_PARITY_EN
                    PARITY: state <= STOP;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
